// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage with operand forwarding, multi-cycle multiply and branch resolution
// Non-MUL ops register in one cycle; MUL holds the stage via stall_req and emits bubbles until done.
module ex_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [2:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc,
  input  logic              fwd_mem_we,
  input  logic              fwd_wb_we,
  input  logic [4:0]        fwd_mem_rd,
  input  logic [4:0]        fwd_wb_rd,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              stall_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        rd_out,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [CNT_W-1:0]  branch_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;

  localparam bit         MULTI_CYCLE = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD    = 4'(MUL_CYCLES - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        mul_cnt;

  logic              accept;
  logic              is_mul;
  logic              mul_start;
  logic              mul_done;
  logic              issue;
  logic              beq_taken;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mul_res;
  logic [4:0]        dst;

  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_sd;
  logic [4:0]        mul_rd;
  logic              mul_mr;
  logic              mul_mw;
  logic              mul_rw;
  logic              mul_m2r;

  // Forwarding: the younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_a = rs_data;
    if (rs_addr != 5'd0 && fwd_mem_we && fwd_mem_rd == rs_addr) begin
      fwd_a = fwd_mem_data;
    end else if (rs_addr != 5'd0 && fwd_wb_we && fwd_wb_rd == rs_addr) begin
      fwd_a = fwd_wb_data;
    end
  end

  always_comb begin
    fwd_b = rt_data;
    if (rt_addr != 5'd0 && fwd_mem_we && fwd_mem_rd == rt_addr) begin
      fwd_b = fwd_mem_data;
    end else if (rt_addr != 5'd0 && fwd_wb_we && fwd_wb_rd == rt_addr) begin
      fwd_b = fwd_wb_data;
    end
  end

  assign alu_b = alu_src ? imm : fwd_b;
  assign dst   = reg_dst ? rd_addr : rt_addr;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:         alu_res = fwd_a + alu_b;
      OP_SUB, OP_BEQ: alu_res = fwd_a - alu_b;
      OP_MUL:         alu_res = fwd_a * alu_b;
      OP_AND:         alu_res = fwd_a & alu_b;
      OP_OR:          alu_res = fwd_a | alu_b;
      OP_SLT:         alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      default:        alu_res = '0;
    endcase
  end

  assign mul_res   = mul_a * mul_b;
  assign is_mul    = (alu_op == OP_MUL);
  assign beq_taken = (alu_op == OP_BEQ) && branch && (fwd_a == fwd_b);

  // Flush and reset both block acceptance so nothing enters the stage on those cycles.
  assign accept = (state == IDLE) && in_valid && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul && MULTI_CYCLE) begin
          state_next = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (flush || mul_cnt == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_start = accept && is_mul && MULTI_CYCLE;
    issue     = accept && !(is_mul && MULTI_CYCLE);
    mul_done  = (state == MUL_BUSY) && !flush && (mul_cnt == 4'd1);
    stall_req = (state == MUL_BUSY) || mul_start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (mul_start) begin
      mul_cnt <= MUL_LOAD;
    end else if (state == MUL_BUSY) begin
      mul_cnt <= flush ? 4'd0 : mul_cnt - 4'd1;
    end
  end

  // Multiply operands and controls are captured at acceptance; upstream may change them while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sd  <= '0;
      mul_rd  <= '0;
      mul_mr  <= 1'b0;
      mul_mw  <= 1'b0;
      mul_rw  <= 1'b0;
      mul_m2r <= 1'b0;
    end else if (mul_start) begin
      mul_a   <= fwd_a;
      mul_b   <= alu_b;
      mul_sd  <= fwd_b;
      mul_rd  <= dst;
      mul_mr  <= mem_read;
      mul_mw  <= mem_write;
      mul_rw  <= reg_write;
      mul_m2r <= mem_to_reg;
    end
  end

  // Every cycle that produces no result is a bubble: valid and controls low, data held.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      result        <= '0;
      store_data    <= '0;
      rd_out        <= '0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      reg_write_o   <= 1'b0;
      mem_to_reg_o  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      branch_count  <= '0;
    end else begin
      out_valid    <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      branch_taken <= 1'b0;
      if (issue) begin
        out_valid     <= 1'b1;
        result        <= alu_res;
        store_data    <= fwd_b;
        rd_out        <= dst;
        mem_read_o    <= mem_read;
        mem_write_o   <= mem_write;
        reg_write_o   <= reg_write;
        mem_to_reg_o  <= mem_to_reg;
        branch_target <= pc + imm;
        if (beq_taken) begin
          branch_taken <= 1'b1;
          if (branch_count != {CNT_W{1'b1}}) begin
            branch_count <= branch_count + CNT_W'(1);
          end
        end
      end else if (mul_done) begin
        out_valid    <= 1'b1;
        result       <= mul_res;
        store_data   <= mul_sd;
        rd_out       <= mul_rd;
        mem_read_o   <= mul_mr;
        mem_write_o  <= mul_mw;
        reg_write_o  <= mul_rw;
        mem_to_reg_o <= mul_m2r;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - self-checking bench for ex_stage_mc
// Expected results are queued when an instruction is driven and popped when out_valid rises.
module tb_ex_stage_mc;
  localparam int W = 32;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] OR_ = 3'b100, SLT = 3'b101, BEQ = 3'b110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, flush;
  logic [2:0] alu_op;
  logic alu_src, reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic [4:0] rs_addr, rt_addr, rd_addr;
  logic [W-1:0] rs_data, rt_data, imm, pc;
  logic fwd_mem_we, fwd_wb_we;
  logic [4:0] fwd_mem_rd, fwd_wb_rd;
  logic [W-1:0] fwd_mem_data, fwd_wb_data;

  logic stall_req, out_valid, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, branch_taken;
  logic [W-1:0] result, store_data, branch_target;
  logic [4:0] rd_out;
  logic [15:0] branch_count;

  logic c2_stall_req, c2_out_valid, c2_mem_read_o, c2_mem_write_o, c2_reg_write_o, c2_mem_to_reg_o, c2_branch_taken;
  logic [W-1:0] c2_result, c2_store_data, c2_branch_target;
  logic [4:0] c2_rd_out;
  logic [1:0] c2_branch_count;

  ex_stage_mc #(.DATA_W(W), .MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rs_data(rs_data),
    .rt_data(rt_data), .imm(imm), .pc(pc), .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_data(fwd_wb_data), .stall_req(stall_req), .out_valid(out_valid),
    .result(result), .store_data(store_data), .rd_out(rd_out), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .branch_taken(branch_taken), .branch_target(branch_target), .branch_count(branch_count)
  );

  ex_stage_mc #(.DATA_W(W), .MUL_CYCLES(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rs_data(rs_data),
    .rt_data(rt_data), .imm(imm), .pc(pc), .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_data(fwd_wb_data), .stall_req(c2_stall_req), .out_valid(c2_out_valid),
    .result(c2_result), .store_data(c2_store_data), .rd_out(c2_rd_out),
    .mem_read_o(c2_mem_read_o), .mem_write_o(c2_mem_write_o), .reg_write_o(c2_reg_write_o),
    .mem_to_reg_o(c2_mem_to_reg_o), .branch_taken(c2_branch_taken),
    .branch_target(c2_branch_target), .branch_count(c2_branch_count)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] sd;
    logic [4:0]   rd;
    logic         rw, mr, mw, m2r;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fwd(input logic [4:0] a, input logic [W-1:0] d);
    if (a != 5'd0 && fwd_mem_we && fwd_mem_rd == a) return fwd_mem_data;
    if (a != 5'd0 && fwd_wb_we && fwd_wb_rd == a) return fwd_wb_data;
    return d;
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [W-1:0] a, b, bb;
    a  = fwd(rs_addr, rs_data);
    b  = fwd(rt_addr, rt_data);
    bb = alu_src ? imm : b;
    case (alu_op)
      ADD:      e.res = a + bb;
      SUB, BEQ: e.res = a - bb;
      MUL:      e.res = a * bb;
      AND_:     e.res = a & bb;
      OR_:      e.res = a | bb;
      SLT:      e.res = ($signed(a) < $signed(bb)) ? 1 : 0;
      default:  e.res = '0;
    endcase
    e.sd  = b;
    e.rd  = reg_dst ? rd_addr : rt_addr;
    e.rw  = reg_write;
    e.mr  = mem_read;
    e.mw  = mem_write;
    e.m2r = mem_to_reg;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_result", result, mon_e.res);
        check("sb_store_data", store_data, mon_e.sd);
        check("sb_rd_out", rd_out, mon_e.rd);
        check("sb_ctrl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
              {mon_e.rw, mon_e.mr, mon_e.mw, mon_e.m2r});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; alu_op = ADD; alu_src = 0; reg_dst = 0; branch = 0;
    mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0; imm = 0; pc = 0;
    fwd_mem_we = 0; fwd_wb_we = 0; fwd_mem_rd = 0; fwd_wb_rd = 0; fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rw);
    alu_op = op; rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = a; rt_data = b;
    reg_write = rw; reg_dst = 1; alu_src = 0; branch = 0; mem_read = 0; mem_write = 0;
    mem_to_reg = 0; imm = 0; pc = 0; in_valid = 1;
  endtask

  task automatic fire();
    push_exp();
    tick();
  endtask

  int stalls, bubbles, valids;

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_req, 0);
    check("rst_result", result, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_branch_target", branch_target, 0);
    check("rst_branch_count", branch_count, 0);
    reset = 0;

    set_op(ADD, 1, 2, 3, 5, 7, 1);
    fire();
    check("add_5_7", result, 12);
    check("add_valid", out_valid, 1);
    check("add_reg_write", reg_write_o, 1);

    set_op(ADD, 3, 4, 6, 1000, 1, 1);
    fwd_mem_we = 1; fwd_mem_rd = 3; fwd_mem_data = 100;
    fwd_wb_we = 1;  fwd_wb_rd = 3;  fwd_wb_data = 200;
    fire();
    check("fwd_mem_priority", result, 101);
    fwd_mem_we = 0;
    fire();
    check("fwd_wb", result, 201);
    set_op(ADD, 0, 4, 6, 55, 1, 1);
    fwd_mem_we = 1; fwd_mem_rd = 0; fwd_wb_rd = 0;
    fire();
    check("fwd_r0_ignored", result, 56);
    set_op(ADD, 1, 4, 6, 10, 1, 1);
    fwd_mem_we = 0; fwd_wb_we = 1; fwd_wb_rd = 4; fwd_wb_data = 9;
    fire();
    check("fwd_b", result, 19);
    alu_src = 1; imm = 1000; mem_write = 1; reg_write = 0;
    fire();
    check("imm_result", result, 1010);
    check("store_fwd_b", store_data, 9);
    check("store_mem_write", mem_write_o, 1);
    fwd_wb_we = 0;

    set_op(SUB, 1, 2, 7, 3, 5, 1);
    fire();
    check("sub_3_5", result, 32'hFFFF_FFFE);
    set_op(SLT, 1, 2, 7, 32'hFFFF_FFFF, 1, 1);
    fire();
    check("slt_m1_1", result, 1);
    set_op(SLT, 1, 2, 7, 1, 32'hFFFF_FFFF, 1);
    fire();
    check("slt_1_m1", result, 0);
    set_op(AND_, 1, 2, 9, 32'hF0F0, 32'hFF00, 1);
    reg_dst = 0;
    fire();
    check("and_val", result, 32'hF000);
    check("rd_from_rt", rd_out, 2);
    set_op(OR_, 1, 2, 9, 32'hF0F0, 32'hFF00, 1);
    fire();
    check("or_val", result, 32'hFFF0);
    in_valid = 0;
    tick();
    check("bubble_valid", out_valid, 0);
    check("bubble_ctrl", reg_write_o, 0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] ops [5];
      ops[0] = ADD; ops[1] = SUB; ops[2] = AND_; ops[3] = OR_; ops[4] = SLT;
      set_op(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      reg_dst = 1'($urandom_range(0, 1)); alu_src = 1'($urandom_range(0, 1)); imm = $urandom;
      mem_read = 1'($urandom_range(0, 1)); mem_to_reg = mem_read;
      fwd_mem_we = 1'($urandom_range(0, 1)); fwd_mem_rd = 5'($urandom_range(0, 7)); fwd_mem_data = $urandom;
      fwd_wb_we = 1'($urandom_range(0, 1));  fwd_wb_rd = 5'($urandom_range(0, 7));  fwd_wb_data = $urandom;
      fire();
    end
    idle_inputs();
    tick();

    set_op(MUL, 1, 2, 5, 6, 7, 1);
    push_exp();
    #1;
    check("mul_stall_accept", stall_req, 1);
    stalls = 1; bubbles = 0; valids = 0;
    tick();
    in_valid = 0; rs_data = 99; rt_data = 99;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (stall_req) stalls++;
      if (out_valid) begin
        valids++;
        check("mul_42", result, 42);
      end else if (stall_req) begin
        bubbles++;
      end
      tick();
      #1;
    end
    check("mul_stall_cycles", stalls, 4);
    check("mul_bubbles", bubbles, 3);
    check("mul_valid_once", valids, 1);

    set_op(MUL, 1, 2, 5, 6, 7, 1);
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    #1;
    check("mul_flush_idle", stall_req, 0);
    check("mul_flush_valid", out_valid, 0);
    valids = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) valids++;
    end
    check("mul_flush_no_result", valids, 0);

    set_op(ADD, 1, 2, 3, 1, 1, 1);
    flush = 1;
    tick();
    check("flush_beats_valid", out_valid, 0);
    check("flush_ctrl", reg_write_o, 0);
    flush = 0; in_valid = 0;
    tick();

    set_op(BEQ, 1, 2, 0, 9, 9, 0);
    branch = 1; pc = 40; imm = 32'hFFFF_FFF8;
    fire();
    check("beq_taken", branch_taken, 1);
    check("beq_target", branch_target, 32);
    check("beq_count", branch_count, 1);
    check("beq_result", result, 0);
    in_valid = 0;
    tick();
    check("beq_pulse_end", branch_taken, 0);
    set_op(BEQ, 1, 2, 0, 9, 8, 0);
    branch = 1;
    fire();
    check("beq_not_taken", branch_taken, 0);
    check("beq_count_hold", branch_count, 1);
    set_op(BEQ, 1, 2, 0, 4, 4, 0);
    branch = 1;
    for (int i = 0; i < 5; i++) fire();
    in_valid = 0;
    tick();
    check("count16_after_6", branch_count, 6);
    check("count2_saturate", c2_branch_count, 3);

    set_op(ADD, 1, 2, 3, 11, 22, 1);
    mem_write = 1;
    fire();
    set_op(MUL, 1, 2, 5, 3, 3, 1);
    tick();
    in_valid = 0; reset = 1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_stall", stall_req, 0);
    check("midrst_result", result, 0);
    check("midrst_store", store_data, 0);
    check("midrst_rd", rd_out, 0);
    check("midrst_ctrl", {reg_write_o, mem_write_o}, 0);
    check("midrst_count", branch_count, 0);
    check("midrst_target", branch_target, 0);
    reset = 0;
    valids = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) valids++;
    end
    check("midrst_no_mul", valids, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand, result, pc width.
REQ-002 SHALL have parameter MUL_CYCLES, default 4 (range 1..16): multiply latency in cycles.
REQ-003 SHALL have parameter CNT_W, default 16: branch counter width.
REQ-004 SHALL have ports; clock and reset are clk and reset, one clock, reset synchronous and active-high:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- in_valid  in  1  ID/EX holds an instruction
- flush  in  1  kill in-flight and incoming instruction
- alu_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 SLT (signed), 110 BEQ
- alu_src, reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg  in  1 each  decoded controls
- rs_addr, rt_addr, rd_addr  in  5  register numbers
- rs_data, rt_data, imm, pc  in  DATA_W  operands, sign-extended immediate, instruction pc
- fwd_mem_we, fwd_wb_we  in  1  EX/MEM and MEM/WB write enables
- fwd_mem_rd, fwd_wb_rd  in  5  their destinations
- fwd_mem_data, fwd_wb_data  in  DATA_W  their results
- stall_req  out  1  upstream must hold ID/EX
- out_valid  out  1  EX/MEM slot valid
- result, store_data  out  DATA_W  ALU result; forwarded rt for stores
- rd_out  out  5  destination
- mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o  out  1  registered controls
- branch_taken  out  1  one-cycle taken pulse
- branch_target  out  DATA_W  pc + imm
- branch_count  out  CNT_W  taken-branch count

Function
REQ-005 SHALL forward operand A from fwd_mem_data if fwd_mem_we and fwd_mem_rd==rs_addr, else fwd_wb_data if fwd_wb_we and fwd_wb_rd==rs_addr, else rs_data; same for B with rt_addr/rt_data.
REQ-006 SHALL never forward when the matching address is 0.
REQ-007 SHALL select ALU operand B = imm when alu_src=1, else forwarded B; store_data SHALL always be forwarded B.
REQ-008 SHALL compute ADD/SUB/AND/OR modulo 2^DATA_W; SLT SHALL yield 1 or 0; MUL SHALL yield low DATA_W bits of the product.
REQ-009 SHALL set rd_out = rd_addr if reg_dst=1, else rt_addr.
REQ-010 SHALL register non-MUL results and controls one cycle after acceptance (latency 1).
REQ-011 SHALL implement FSM IDLE/MUL_BUSY: IDLE accepts on in_valid; MUL enters MUL_BUSY with counter MUL_CYCLES-1; returns to IDLE when counter hits 0 and result registers.
REQ-012 SHALL hold stall_req=1 while in MUL_BUSY, and on the accepting cycle combinationally when MUL_CYCLES>1; operands SHALL be latched at acceptance.
REQ-013 SHALL drive out_valid=0 and all control outputs 0 on every cycle MUL_BUSY produces no result (bubble insertion).
REQ-014 SHALL, for BEQ, pulse branch_taken for one cycle when branch=1 and operand A==forwarded B; branch_target SHALL be pc+imm; ALU result SHALL be A-B.
REQ-015 SHALL increment branch_count per taken branch, saturating at 2^CNT_W-1.
REQ-016 SHALL, on flush, drive out_valid=0, controls 0, branch_taken 0 next cycle, abort MUL_BUSY to IDLE, and accept no instruction that cycle; flush SHALL beat in_valid.
REQ-017 SHALL treat in_valid=0 as a bubble: outputs valid/controls 0, result don't-care-held.
REQ-018 SHALL, after a taken branch, drive no extra action; upstream asserts flush.

Reset
REQ-019 SHALL, while reset=1 at a clk edge, clear FSM to IDLE, mul counter, out_valid, stall_req, branch_taken, all control outputs, result, store_data, rd_out, branch_target, branch_count to 0.
REQ-020 SHALL, with reset mid-MUL, discard the multiply and emit no result.

Verification
REQ-021 ADD rs=5,rt=7, no hazards -> next cycle result=12, out_valid=1, reg_write_o=1.
REQ-022 rs_addr=3 with fwd_mem_rd=3 (data 100) and fwd_wb_rd=3 (data 200), both we=1 -> A=100; rs_addr=0 with fwd_mem_rd=0 -> rs_data used.
REQ-023 MUL 6*7, MUL_CYCLES=4 -> stall_req high 4 cycles, 3 bubbles, result=42 valid once; flush on cycle 2 -> no result, IDLE.
REQ-024 BEQ A=B=9, branch=1, pc=40, imm=-8 -> branch_taken one cycle, target=32, branch_count 0->1; CNT_W=2 with 5 taken -> count stays 3.
REQ-025 SUB 3-5 -> result 0xFFFFFFFE; SLT -1,1 -> 1; reset asserted mid-stream -> all outputs 0 next edge.
